// File: rtl/button_event_classifier_if.sv
// Key-event bus between the debounce front end and the click classifier.
interface button_event_classifier_if;
    logic       iPress_pulse;
    logic       iKey_level;
    logic       oSingle_click;
    logic       oDouble_click;
    logic       oLong_press;
    logic       oBusy;
    logic [7:0] oEvent_cnt;

    modport master (
        output iPress_pulse, iKey_level,
        input  oSingle_click, oDouble_click, oLong_press, oBusy, oEvent_cnt
    );

    modport slave (
        input  iPress_pulse, iKey_level,
        output oSingle_click, oDouble_click, oLong_press, oBusy, oEvent_cnt
    );
endinterface

// File: rtl/button_event_classifier.sv
// Classifies debounced key presses into single-click, double-click and long-press pulses.
// Long-press detection (PEND_LONG/HOLD) is built only when LONG_PRESS_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a first press
// WIN       | double-click window running after the first press
// PEND_LONG | window expired with key still down; waiting for release or long hold
// HOLD      | long press reported; waiting for release
module button_event_classifier #(
    parameter int CNT_W      = 16,
    parameter int DOUBLE_WIN = 20000,
    parameter int LONG_HOLD  = 40000
) (
    input  logic iCLK,
    input  logic iRST_n,
    button_event_classifier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WIN       = 2'd1,
        PEND_LONG = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // Down-counter: the press cycle is window cycle 0, so expiry lands DOUBLE_WIN-1 cycles later.
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(DOUBLE_WIN - 2);
    localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] PEND_LOAD = CNT_W'(LONG_HOLD - DOUBLE_WIN - 1);
`endif

    generate
        if (DOUBLE_WIN < 2 || LONG_HOLD <= DOUBLE_WIN || (LONG_HOLD >> CNT_W) != 0) begin : gBadParams
            $error("button_event_classifier: need 2 <= DOUBLE_WIN < LONG_HOLD < 2**CNT_W");
        end
    endgenerate

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmrNext;
    logic             singleNext;
    logic             doubleNext;
    logic             eventNext;
    logic             singleQ;
    logic             doubleQ;
    logic [7:0]       eventCnt;
`ifdef LONG_PRESS_EN
    logic             longNext;
    logic             longQ;
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            tmr      <= '0;
            singleQ  <= 1'b0;
            doubleQ  <= 1'b0;
            eventCnt <= 8'd0;
`ifdef LONG_PRESS_EN
            longQ    <= 1'b0;
`endif
        end else begin
            state   <= stateNext;
            tmr     <= tmrNext;
            singleQ <= singleNext;
            doubleQ <= doubleNext;
`ifdef LONG_PRESS_EN
            longQ   <= longNext;
`endif
            if (eventNext && eventCnt != 8'hFF) begin
                eventCnt <= eventCnt + 8'd1;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        tmrNext    = tmr;
        singleNext = 1'b0;
        doubleNext = 1'b0;
`ifdef LONG_PRESS_EN
        longNext   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.iPress_pulse) begin
                    stateNext = WIN;
                    tmrNext   = WIN_LOAD;
                end
            end
            WIN: begin
                // A second press wins even when it coincides with window expiry.
                if (bus.iPress_pulse) begin
                    doubleNext = 1'b1;
                    stateNext  = IDLE;
                    tmrNext    = '0;
                end else if (tmr != '0) begin
                    tmrNext = tmr - TMR_ONE;
`ifdef LONG_PRESS_EN
                end else if (!bus.iKey_level) begin
                    stateNext = PEND_LONG;
                    tmrNext   = PEND_LOAD;
`endif
                end else begin
                    singleNext = 1'b1;
                    stateNext  = IDLE;
                end
            end
            PEND_LONG: begin
                if (bus.iKey_level) begin
                    singleNext = 1'b1;
                    stateNext  = IDLE;
                    tmrNext    = '0;
                end else if (tmr == '0) begin
`ifdef LONG_PRESS_EN
                    longNext  = 1'b1;
`endif
                    stateNext = HOLD;
                end else begin
                    tmrNext = tmr - TMR_ONE;
                end
            end
            HOLD: begin
                if (bus.iKey_level) begin
                    stateNext = IDLE;
                    tmrNext   = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                tmrNext   = '0;
            end
        endcase
`ifdef LONG_PRESS_EN
        eventNext = singleNext | doubleNext | longNext;
`else
        eventNext = singleNext | doubleNext;
`endif
    end

    assign bus.oSingle_click = singleQ;
    assign bus.oDouble_click = doubleQ;
    assign bus.oBusy         = (state != IDLE);
    assign bus.oEvent_cnt    = eventCnt;
`ifdef LONG_PRESS_EN
    assign bus.oLong_press   = longQ;
`else
    assign bus.oLong_press   = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier (DOUBLE_WIN=10, LONG_HOLD=30) with an event-level model.
module tb_button_event_classifier;

    localparam int DW = 10;
    localparam int LH = 30;
    localparam int NMAX = 128;

    logic iCLK = 1'b0;
    logic iRST_n;

    button_event_classifier_if bus();

    button_event_classifier #(
        .CNT_W      (16),
        .DOUBLE_WIN (DW),
        .LONG_HOLD  (LH)
    ) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .bus    (bus.slave)
    );

    always #5 iCLK = ~iCLK;

    int nTests = 0;
    int nFail  = 0;

    bit pressV [NMAX];
    bit keyV   [NMAX];
    bit expS   [NMAX];
    bit expD   [NMAX];
    bit expL   [NMAX];
    bit expB   [NMAX];
    int expC   [NMAX];
    int modelCnt = 0;

    int cyc   = 0;
    bit chkEn = 1'b0;
    int cmpIdx;

    task automatic check(input string nm, input int idx, input int got, input int exp);
        nTests++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, idx, got, exp);
        end
    endtask

    task automatic clearStim();
        for (int k = 0; k < NMAX; k++) begin
            pressV[k] = 1'b0;
            keyV[k]   = 1'b1;
        end
    endtask

    task automatic setKeyLow(input int a, input int b);
        for (int k = a; k <= b; k++) keyV[k] = 1'b0;
    endtask

    // Event-level model: locate first press, look for a second press inside the window,
    // otherwise decide by key level at window end and the release time.
    task automatic buildExpect(input int L);
        int idleFrom, p1, p2, winEnd, r, endC, evAt, evKind, c;
        for (int k = 0; k < NMAX; k++) begin
            expS[k] = 1'b0; expD[k] = 1'b0; expL[k] = 1'b0; expB[k] = 1'b0; expC[k] = 0;
        end
        idleFrom = 0;
        for (int guard = 0; guard < 64; guard++) begin
            p1 = -1;
            for (int k = idleFrom; k < L; k++) if (pressV[k] && p1 < 0) p1 = k;
            if (p1 < 0) break;
            winEnd = p1 + DW - 1;
            p2 = -1;
            for (int k = p1 + 1; k <= winEnd && k < L; k++) if (pressV[k] && p2 < 0) p2 = k;
            evKind = 0; evAt = 0; endC = 0;
            if (p2 >= 0) begin
                evKind = 2; evAt = p2 + 1; endC = evAt;
            end
`ifdef LONG_PRESS_EN
            if (evKind == 0 && !keyV[winEnd]) begin
                r = -1;
                for (int k = winEnd + 1; k < L; k++) if (keyV[k] && r < 0) r = k;
                if (r >= 0 && r <= p1 + LH - 1) begin
                    evKind = 1; evAt = r + 1; endC = evAt;
                end else begin
                    evKind = 3; evAt = p1 + LH;
                    r = -1;
                    for (int k = p1 + LH; k < L; k++) if (keyV[k] && r < 0) r = k;
                    endC = (r < 0) ? L + 1 : r + 1;
                end
            end
`endif
            if (evKind == 0) begin
                evKind = 1; evAt = p1 + DW; endC = evAt;
            end
            for (int k = p1 + 1; k < endC && k <= L; k++) expB[k] = 1'b1;
            if (evAt <= L) begin
                if (evKind == 1) expS[evAt] = 1'b1;
                if (evKind == 2) expD[evAt] = 1'b1;
                if (evKind == 3) expL[evAt] = 1'b1;
            end
            idleFrom = endC;
        end
        c = modelCnt;
        for (int k = 0; k <= L; k++) begin
            if (expS[k] || expD[k] || expL[k]) c = (c >= 255) ? 255 : c + 1;
            expC[k] = c;
        end
        modelCnt = expC[L];
    endtask

    // Called at a falling edge; cycle k's inputs are driven mid-cycle k.
    task automatic runScenario(input int L);
        buildExpect(L);
        for (int k = 0; k < L; k++) begin
            cyc   = k;
            chkEn = 1'b1;
            bus.iPress_pulse = pressV[k];
            bus.iKey_level   = keyV[k];
            @(negedge iCLK);
        end
        chkEn = 1'b0;
        bus.iPress_pulse = 1'b0;
        bus.iKey_level   = 1'b1;
    endtask

    always @(posedge iCLK) begin
        #1;
        if (chkEn) begin
            cmpIdx = cyc + 1;
            check("single", cmpIdx, int'(bus.oSingle_click), int'(expS[cmpIdx]));
            check("double", cmpIdx, int'(bus.oDouble_click), int'(expD[cmpIdx]));
            check("long",   cmpIdx, int'(bus.oLong_press),   int'(expL[cmpIdx]));
            check("busy",   cmpIdx, int'(bus.oBusy),         int'(expB[cmpIdx]));
            check("count",  cmpIdx, int'(bus.oEvent_cnt),    expC[cmpIdx]);
            check("onehot", cmpIdx,
                  (int'(bus.oSingle_click) + int'(bus.oDouble_click) + int'(bus.oLong_press) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic checkQuiet(input string nm);
        check({nm, "_single"}, -1, int'(bus.oSingle_click), 0);
        check({nm, "_double"}, -1, int'(bus.oDouble_click), 0);
        check({nm, "_long"},   -1, int'(bus.oLong_press),   0);
        check({nm, "_busy"},   -1, int'(bus.oBusy),         0);
        check({nm, "_count"},  -1, int'(bus.oEvent_cnt),    0);
    endtask

    initial begin
        iRST_n = 1'b0;
        bus.iPress_pulse = 1'b0;
        bus.iKey_level   = 1'b1;
        repeat (3) @(negedge iCLK);
        checkQuiet("reset");
        iRST_n = 1'b1;

        // single click; press lands on the first edge after reset release
        clearStim(); pressV[0] = 1'b1; setKeyLow(0, 4);
        runScenario(14);
        check("pin_single_at10", -1, int'(expS[10]), 1);
        check("pin_single_not9", -1, int'(expS[9]), 0);
        check("pin_cnt_after_single", -1, expC[13], 1);

        // double click at cycles 0 and 6
        clearStim(); pressV[0] = 1'b1; pressV[6] = 1'b1; setKeyLow(0, 2); setKeyLow(6, 7);
        runScenario(10);
        check("pin_double_at7", -1, int'(expD[7]), 1);
        check("pin_busy_low7", -1, int'(expB[7]), 0);

        // key held through cycle 49, stray press at 40
        clearStim(); pressV[0] = 1'b1; pressV[40] = 1'b1; setKeyLow(0, 49);
        runScenario(56);
`ifdef LONG_PRESS_EN
        check("pin_long_at30", -1, int'(expL[30]), 1);
        check("pin_busy50", -1, int'(expB[50]), 1);
        check("pin_busy51", -1, int'(expB[51]), 0);
`else
        check("pin_single10_nolong", -1, int'(expS[10]), 1);
        check("pin_single50_nolong", -1, int'(expS[50]), 1);
`endif

        // presses at 0 and 9: coincides with window expiry
        clearStim(); pressV[0] = 1'b1; pressV[9] = 1'b1; setKeyLow(0, 1); setKeyLow(9, 9);
        runScenario(13);
        check("pin_double_at10", -1, int'(expD[10]), 1);
        check("pin_no_single10", -1, int'(expS[10]), 0);

        // held 50 cycles, no second press
        clearStim(); pressV[0] = 1'b1; setKeyLow(0, 49);
        runScenario(56);
`ifdef LONG_PRESS_EN
        check("pin_held_long30", -1, int'(expL[30]), 1);
`else
        check("pin_held_single10", -1, int'(expS[10]), 1);
`endif

        // release between window end and long threshold
        clearStim(); pressV[0] = 1'b1; setKeyLow(0, 19);
        runScenario(26);

        // release on the last cycle before the long threshold, then one cycle later
        clearStim(); pressV[0] = 1'b1; setKeyLow(0, 28);
        runScenario(34);
`ifdef LONG_PRESS_EN
        check("pin_edge_single30", -1, int'(expS[30]), 1);
`endif
        clearStim(); pressV[0] = 1'b1; setKeyLow(0, 29);
        runScenario(34);
`ifdef LONG_PRESS_EN
        check("pin_edge_long30", -1, int'(expL[30]), 1);
        check("pin_edge_idle31", -1, int'(expB[31]), 0);
`endif

        // back-to-back: second press in the cycle the single pulse appears
        clearStim(); pressV[0] = 1'b1; pressV[10] = 1'b1; setKeyLow(0, 1); setKeyLow(10, 11);
        runScenario(24);
        check("pin_b2b_single20", -1, int'(expS[20]), 1);

        // reset in the middle of a classification
        clearStim(); pressV[0] = 1'b1; setKeyLow(0, 9);
        runScenario(5);
        iRST_n = 1'b0;
        #1;
        checkQuiet("midreset");
        @(negedge iCLK);
        @(negedge iCLK);
        iRST_n = 1'b1;
        modelCnt = 0;
        clearStim();
        runScenario(36);

        // counter saturation
        for (int i = 0; i < 300; i++) begin
            clearStim(); pressV[0] = 1'b1;
            runScenario(12);
        end
        check("pin_model_sat", -1, modelCnt, 255);
        check("sat_count", -1, int'(bus.oEvent_cnt), 255);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/button_event_classifier.md
BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 Parameter: CNT_W, 16, timer width in bits.
REQ-002 Parameter: DOUBLE_WIN, 20000, double-click window length in iCLK cycles.
REQ-003 Parameter: LONG_HOLD, 40000, press duration in iCLK cycles that qualifies as a long press.
REQ-004 Legal parameters SHALL satisfy 2 <= DOUBLE_WIN < LONG_HOLD < 2^CNT_W.
REQ-005 Port: iCLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port: iRST_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: iPress_pulse  input  1  one-cycle pulse per debounced key press, from the upstream edge/debounce stage.
REQ-008 Port: iKey_level  input  1  synchronised key level; 0 = pressed, 1 = released.
REQ-009 Port: oSingle_click  output  1  one-cycle pulse, single click classified.
REQ-010 Port: oDouble_click  output  1  one-cycle pulse, double click classified.
REQ-011 Port: oLong_press  output  1  one-cycle pulse, long press classified.
REQ-012 Port: oBusy  output  1  high whenever the state is not IDLE.
REQ-013 Port: oEvent_cnt  output  8  count of classified events, saturating.

Function
REQ-014 FSM states SHALL be IDLE, WIN, PEND_LONG and HOLD; all outputs SHALL be registered.
REQ-015 IDLE: iPress_pulse=1 -> WIN, timer=0. Otherwise stay in IDLE.
REQ-016 WIN, iPress_pulse=1: oDouble_click=1 on the next cycle, go to IDLE.
REQ-017 WIN, no press, timer!=DOUBLE_WIN-1: timer increments.
REQ-018 WIN, no press, timer==DOUBLE_WIN-1, iKey_level=1: oSingle_click=1 on the next cycle, go to IDLE.
REQ-019 WIN, no press, timer==DOUBLE_WIN-1, iKey_level=0: go to PEND_LONG (LONG_PRESS_EN defined); timer keeps incrementing.
REQ-020 PEND_LONG, iKey_level=1: oSingle_click=1 on the next cycle, go to IDLE.
REQ-021 PEND_LONG, iKey_level=0, timer==LONG_HOLD-1: oLong_press=1 on the next cycle, go to HOLD.
REQ-022 HOLD: stay until iKey_level=1, then go to IDLE with no pulse.
REQ-023 iPress_pulse SHALL be ignored in PEND_LONG and HOLD.
REQ-024 Simultaneous press and window expiry in WIN SHALL be classified as a double click.
REQ-025 Pulse timing: single = DOUBLE_WIN cycles after the first press sample; double = 1 cycle after the second press sample.
REQ-026 Exactly one of the three event outputs SHALL be high in any cycle, or none.
REQ-027 oEvent_cnt SHALL increment by 1 in the cycle an event pulse is high, and hold at 255.
REQ-028 The timer SHALL never wrap; it is only compared while below LONG_HOLD.

Reset
REQ-029 iRST_n=0 SHALL immediately force IDLE, timer=0, every pulse output=0, oBusy=0 and oEvent_cnt=0.
REQ-030 Reset mid-classification SHALL discard the pending event, with no pulse after release.
REQ-031 The first press sampled on the first edge after reset release SHALL be accepted.

Configuration
REQ-032 Macro LONG_PRESS_EN SHALL control long-press detection.
REQ-033 With LONG_PRESS_EN defined, long-press detection SHALL behave as REQ-019 to REQ-022.
REQ-034 With LONG_PRESS_EN undefined:
- window expiry in WIN SHALL give oSingle_click regardless of iKey_level;
- PEND_LONG and HOLD SHALL be unreachable;
- oLong_press SHALL be constant 0;
- LONG_HOLD SHALL be unused.

Verification (DOUBLE_WIN=10, LONG_HOLD=30, LONG_PRESS_EN defined unless stated)
REQ-035 Bench SHALL cover: press at cycle 0, released by cycle 5 -> oSingle_click high in cycle 10 only; oEvent_cnt=1.
REQ-036 Bench SHALL cover: presses at cycles 0 and 6 -> oDouble_click high in cycle 7; no single pulse; oBusy low from cycle 7.
REQ-037 Bench SHALL cover: press at cycle 0, key held to cycle 50 -> oLong_press high in cycle 30; oBusy low in cycle 51; second press at cycle 40 ignored.
REQ-038 Bench SHALL cover: presses at cycles 0 and 9 -> double pulse in cycle 10; no single pulse.
REQ-039 Bench SHALL cover: reset asserted at cycle 5 after a press at cycle 0 -> no pulse through cycle 40; oEvent_cnt=0; 300 single clicks -> oEvent_cnt=255.
REQ-040 Bench SHALL cover, with LONG_PRESS_EN undefined: press at cycle 0, held 50 cycles -> oSingle_click in cycle 10; oLong_press never high.
